// File: rtl/dccm_arb.sv
// dccm_arb: shares the single DCCM port between the core LSU and a DMA master.
// The LSU has fixed priority. A starvation counter forces a DMA grant after
// MAX_WAIT consecutive denials. An owner pipeline matched to RD_LAT steers each
// read response back to the requester that issued it.
module dccm_arb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_gnt,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_rvalid,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [XLEN-1:0] dma_addr,
  input  logic [XLEN-1:0] dma_wdata,
  output logic            dma_gnt,
  output logic [XLEN-1:0] dma_rdata,
  output logic            dma_rvalid,
  output logic [XLEN-1:0] dccm_raddr,
  output logic            dccm_rvalid_in,
  input  logic [XLEN-1:0] dccm_rdata,
  input  logic            dccm_rvalid_out,
  output logic [XLEN-1:0] dccm_waddr,
  output logic            dccm_wen,
  output logic [XLEN-1:0] dccm_wdata,
  output logic            arb_err
);

  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [RD_LAT-1:0] own_vld_q, own_vld_d;
  logic [RD_LAT-1:0] own_id_q, own_id_d;
  logic [XLEN-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic [XLEN-1:0]   dma_rdata_q, dma_rdata_d;
  logic              arb_err_q, arb_err_d;

  logic            force_dma;
  logic            sel_we;
  logic [XLEN-1:0] sel_addr;
  logic [XLEN-1:0] sel_wdata;
  logic            any_gnt;
  logic            rd_gnt;
  logic            last_vld;
  logic            last_id;

  // Zero-cycle arbitration and DCCM command drive for the winner.
  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    force_dma = (wait_cnt_q == WAIT_MAX);
    dma_gnt   = !rst && dma_req && (!lsu_req || force_dma);
    lsu_gnt   = !rst && lsu_req && !dma_gnt;
    any_gnt   = lsu_gnt || dma_gnt;
    sel_we    = dma_gnt ? dma_we    : lsu_we;
    sel_addr  = dma_gnt ? dma_addr  : lsu_addr;
    sel_wdata = dma_gnt ? dma_wdata : lsu_wdata;
    rd_gnt    = any_gnt && !sel_we;

    dccm_raddr     = '0;
    dccm_rvalid_in = 1'b0;
    dccm_waddr     = '0;
    dccm_wdata     = '0;
    dccm_wen       = 1'b0;
    if (rd_gnt) begin
      dccm_raddr     = sel_addr;
      dccm_rvalid_in = 1'b1;
    end else if (any_gnt) begin
      dccm_waddr = sel_addr;
      dccm_wdata = sel_wdata;
      dccm_wen   = 1'b1;
    end
  end

  // Starvation counter: counts consecutive denied DMA cycles, saturating.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dma_gnt || !dma_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Owner pipeline shift and response steering back to the issuing requester.
  always_comb begin
    own_vld_d    = '0;
    own_id_d     = '0;
    own_vld_d[0] = rd_gnt;
    own_id_d[0]  = dma_gnt;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      own_vld_d[i] = own_vld_q[i-1];
      own_id_d[i]  = own_id_q[i-1];
    end

    last_vld   = own_vld_q[RD_LAT-1];
    last_id    = own_id_q[RD_LAT-1];
    lsu_rvalid = dccm_rvalid_out && last_vld && !last_id;
    dma_rvalid = dccm_rvalid_out && last_vld &&  last_id;

    // Response data goes straight through in the valid cycle, held otherwise.
    lsu_rdata   = lsu_rvalid ? dccm_rdata : lsu_rdata_q;
    dma_rdata   = dma_rvalid ? dccm_rdata : dma_rdata_q;
    lsu_rdata_d = lsu_rdata;
    dma_rdata_d = dma_rdata;

    // Either an orphan response or a missing expected response is an error.
    arb_err_d = arb_err_q || (dccm_rvalid_out != last_vld);
    arb_err   = arb_err_q;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      own_vld_q   <= '0;
      own_id_q    <= '0;
      lsu_rdata_q <= '0;
      dma_rdata_q <= '0;
      arb_err_q   <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      own_vld_q   <= own_vld_d;
      own_id_q    <= own_id_d;
      lsu_rdata_q <= lsu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      arb_err_q   <= arb_err_d;
    end
  end

endmodule

// File: tb/tb_dccm_arb.sv
// tb_dccm_arb: directed vectors for dccm_arb. u_dut1 uses RD_LAT=1 and
// u_dut2 uses RD_LAT=2; both see the same requests and each has its own
// DCCM read pipeline over one shared memory model.
module tb_dccm_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_req = 1'b0, lsu_we = 1'b0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        force_rv = 1'b0;

  logic        lg1, dg1, lrv1, drv1, rvi1, rvo1, wen1, err1;
  logic [31:0] lrd1, drd1, raddr1, rd1, waddr1, wdata1;
  logic        lg2, dg2, lrv2, drv2, rvi2, rvo2, wen2, err2;
  logic [31:0] lrd2, drd2, raddr2, rd2, waddr2, wdata2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dccm_arb #(.XLEN(32), .RD_LAT(1), .MAX_WAIT(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lg1), .lsu_rdata(lrd1), .lsu_rvalid(lrv1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dg1), .dma_rdata(drd1), .dma_rvalid(drv1),
    .dccm_raddr(raddr1), .dccm_rvalid_in(rvi1), .dccm_rdata(rd1), .dccm_rvalid_out(rvo1),
    .dccm_waddr(waddr1), .dccm_wen(wen1), .dccm_wdata(wdata1), .arb_err(err1)
  );

  dccm_arb #(.XLEN(32), .RD_LAT(2), .MAX_WAIT(4)) u_dut2 (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lg2), .lsu_rdata(lrd2), .lsu_rvalid(lrv2),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dg2), .dma_rdata(drd2), .dma_rvalid(drv2),
    .dccm_raddr(raddr2), .dccm_rvalid_in(rvi2), .dccm_rdata(rd2), .dccm_rvalid_out(rvo2),
    .dccm_waddr(waddr2), .dccm_wen(wen2), .dccm_wdata(wdata2), .arb_err(err2)
  );

  // DCCM model: memory preloaded while rst is high, written by u_dut1 only.
  logic [31:0] mem [0:255];
  logic        m1_v, m2_v0, m2_v1;
  logic [31:0] m1_d, m2_d0, m2_d1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[0] <= 32'hA0A0_A0A0;
      mem[1] <= 32'hA4A4_A4A4;
      mem[2] <= 32'hA8A8_A8A8;
      mem[4] <= 32'hCAFE_0001;
    end else if (wen1) begin
      mem[waddr1[9:2]] <= wdata1;
    end
    m1_v  <= rvi1;
    m1_d  <= mem[raddr1[9:2]];
    m2_v0 <= rvi2;
    m2_d0 <= mem[raddr2[9:2]];
    m2_v1 <= m2_v0;
    m2_d1 <= m2_d0;
  end

  assign rvo1 = m1_v | force_rv;
  assign rd1  = m1_d;
  assign rvo2 = m2_v1;
  assign rd2  = m2_d1;

  typedef struct {
    logic lr, lw; logic [31:0] la, ld;
    logic dr, dw; logic [31:0] da, dd;
    logic e_lg, e_dg, e_rvi, e_wen, e_lrv, e_drv;
    logic [31:0] e_addr, e_wd, e_lrd, e_drd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    lsu_req = lr; lsu_we = lw; lsu_addr = la; lsu_wdata = ld;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t vt [10];

  initial begin
    //        lr lw la     ld          dr dw da     dd           lg dg rvi wen lrv drv addr   wd           lrd          drd
    vt[0] = '{0, 0, 32'h0, 32'h0,       0, 0, 32'h0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,  32'h0,       32'h0,       32'h0};
    vt[1] = '{1, 0, 32'h10, 32'h0,      0, 0, 32'h0, 32'h0,       1, 0, 1, 0, 0, 0, 32'h10, 32'h0,       32'h0,       32'h0};
    vt[2] = '{0, 0, 32'h0, 32'h0,       0, 0, 32'h0, 32'h0,       0, 0, 0, 0, 1, 0, 32'h0,  32'h0,       32'hCAFE0001, 32'h0};
    vt[3] = '{0, 0, 32'h0, 32'h0,       0, 0, 32'h0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,  32'h0,       32'hCAFE0001, 32'h0};
    vt[4] = '{0, 0, 32'h0, 32'h0,       1, 1, 32'h20, 32'h12345678, 0, 1, 0, 1, 0, 0, 32'h20, 32'h12345678, 32'hCAFE0001, 32'h0};
    vt[5] = '{1, 0, 32'h20, 32'h0,      0, 0, 32'h0, 32'h0,       1, 0, 1, 0, 0, 0, 32'h20, 32'h0,       32'hCAFE0001, 32'h0};
    vt[6] = '{0, 0, 32'h0, 32'h0,       0, 0, 32'h0, 32'h0,       0, 0, 0, 0, 1, 0, 32'h0,  32'h0,       32'h12345678, 32'h0};
    vt[7] = '{1, 1, 32'h40, 32'h11,     1, 0, 32'h4, 32'h0,       1, 0, 0, 1, 0, 0, 32'h40, 32'h11,      32'h12345678, 32'h0};
    vt[8] = '{0, 0, 32'h0, 32'h0,       1, 0, 32'h4, 32'h0,       0, 1, 1, 0, 0, 0, 32'h4,  32'h0,       32'h12345678, 32'h0};
    vt[9] = '{0, 0, 32'h0, 32'h0,       0, 0, 32'h0, 32'h0,       0, 0, 0, 0, 0, 1, 32'h0,  32'h0,       32'h12345678, 32'hA4A4A4A4};

    // Reset state (checked while rst is held).
    @(negedge clk); #2;
    chk("rst_lsu_gnt", lg1, 0);
    chk("rst_err", err1, 0);
    chk("rst_lrd", lrd1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors on u_dut1 (RD_LAT=1).
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].lr, vt[i].lw, vt[i].la, vt[i].ld, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
      chk($sformatf("v%0d_lsu_gnt", i), lg1, vt[i].e_lg);
      chk($sformatf("v%0d_dma_gnt", i), dg1, vt[i].e_dg);
      chk($sformatf("v%0d_rvalid_in", i), rvi1, vt[i].e_rvi);
      chk($sformatf("v%0d_wen", i), wen1, vt[i].e_wen);
      chk($sformatf("v%0d_addr", i), raddr1 | waddr1, vt[i].e_addr);
      chk($sformatf("v%0d_wdata", i), wdata1, vt[i].e_wd);
      chk($sformatf("v%0d_lsu_rvalid", i), lrv1, vt[i].e_lrv);
      chk($sformatf("v%0d_dma_rvalid", i), drv1, vt[i].e_drv);
      chk($sformatf("v%0d_lsu_rdata", i), lrd1, vt[i].e_lrd);
      chk($sformatf("v%0d_dma_rdata", i), drd1, vt[i].e_drd);
    end

    // Starvation: both reading continuously -> L L L L D repeating.
    begin
      logic prev_l, prev_d;
      prev_l = 0; prev_d = 0;
      for (int k = 0; k < 10; k++) begin
        logic exp_d;
        exp_d = ((k % 5) == 4);
        drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        chk($sformatf("starve%0d_dma_gnt", k), dg1, exp_d);
        chk($sformatf("starve%0d_lsu_gnt", k), lg1, !exp_d);
        chk($sformatf("starve%0d_lsu_rvalid", k), lrv1, prev_l);
        chk($sformatf("starve%0d_dma_rvalid", k), drv1, prev_d);
        if (prev_l) chk($sformatf("starve%0d_lsu_rdata", k), lrd1, 32'hA0A0A0A0);
        if (prev_d) chk($sformatf("starve%0d_dma_rdata", k), drd1, 32'hA4A4A4A4);
        if (exp_d) chk($sformatf("starve%0d_wait_clr", k), u_dut1.wait_cnt_q, 4);
        prev_l = !exp_d; prev_d = exp_d;
      end
      idle();
      chk("starve_drain_dma_rvalid", drv1, 1);
      chk("starve_drain_lsu_rvalid", lrv1, 0);
      chk("starve_wait_zero", u_dut1.wait_cnt_q, 0);
      idle();
    end

    // Alternating reads on u_dut2 (RD_LAT=2): responses 2 cycles after grant.
    begin
      logic e_lg [6] = '{1, 0, 1, 0, 0, 0};
      logic e_dg [6] = '{0, 1, 0, 0, 0, 0};
      logic e_lv [6] = '{0, 0, 1, 0, 1, 0};
      logic e_dv [6] = '{0, 0, 0, 1, 0, 0};
      logic [31:0] e_rd [6] = '{32'h0, 32'h0, 32'hA0A0A0A0, 32'hA4A4A4A4, 32'hA8A8A8A8, 32'h0};
      for (int c = 0; c < 6; c++) begin
        case (c)
          0: drive(1, 0, 32'h0, 0, 0, 0, 0, 0);
          1: drive(0, 0, 0, 0, 1, 0, 32'h4, 0);
          2: drive(1, 0, 32'h8, 0, 0, 0, 0, 0);
          default: idle();
        endcase
        chk($sformatf("alt%0d_lsu_gnt", c), lg2, e_lg[c]);
        chk($sformatf("alt%0d_dma_gnt", c), dg2, e_dg[c]);
        chk($sformatf("alt%0d_lsu_rvalid", c), lrv2, e_lv[c]);
        chk($sformatf("alt%0d_dma_rvalid", c), drv2, e_dv[c]);
        if (e_lv[c]) chk($sformatf("alt%0d_lsu_rdata", c), lrd2, e_rd[c]);
        if (e_dv[c]) chk($sformatf("alt%0d_dma_rdata", c), drd2, e_rd[c]);
      end
      chk("alt_err2", err2, 0);
    end

    // Orphan response on u_dut1: no rvalid, sticky arb_err.
    @(negedge clk);
    force_rv = 1'b1;
    #2;
    chk("orphan_lsu_rvalid", lrv1, 0);
    chk("orphan_dma_rvalid", drv1, 0);
    chk("orphan_err_before", err1, 0);
    @(negedge clk);
    force_rv = 1'b0;
    #2;
    chk("orphan_err_set", err1, 1);
    repeat (3) idle();
    chk("orphan_err_sticky", err1, 1);
    chk("orphan_err2_clear", err2, 0);

    // Reset one cycle after a granted read: everything drops at once.
    drive(1, 0, 32'h8, 0, 0, 0, 0, 0);
    chk("rstflt_grant", lg1, 1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rstflt_lsu_gnt", lg1, 0);
    chk("rstflt_rvalid_in", rvi1, 0);
    chk("rstflt_lsu_rvalid", lrv1, 0);
    chk("rstflt_err", err1, 0);
    chk("rstflt_lrd", lrd1, 0);
    chk("rstflt_drd", drd1, 0);
    chk("rstflt_wait", u_dut1.wait_cnt_q, 0);
    lsu_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) idle();
    chk("post_rst_err1", err1, 0);
    chk("post_rst_err2", err2, 0);
    chk("post_rst_lrv1", lrv1, 0);
    chk("post_rst_lrv2", lrv2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
